data_encryption_tx: RTL and testbench

- Transmit-side encoder for the dual-rail 10-bit framed nibble protocol. It produces the frame pair that the data_encryption receiver checks and decodes.
- It accepts 4-bit payload nibbles over a valid/ready handshake, buffers them in a small FIFO, and wraps each one into a complementary frame pair (frame1/frame2).
- Each frame pair is presented on a valid/ready output handshake. A programmable idle gap is inserted between frames.
- Sits between the payload source and the encoded link toward the reader.

---
 rtl/data_encryption_tx.sv | 177 +++++++++++++++++
 tb/tb_data_encryption_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_encryption_tx.sv
// data_encryption_tx: transmit-side encoder for the dual-rail 10-bit framed
// nibble protocol. Payload nibbles are buffered in a small FIFO. Each one is
// wrapped into a complementary frame pair and presented on a valid/ready
// handshake. A programmable idle gap follows every accepted frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   din          payload nibble
//   din_valid    din holds a nibble to push
//   din_ready    FIFO can accept a nibble (combinational from registered count)
//   frame1       true-rail frame       {3'b001, d, 3'b100}
//   frame2       complement-rail frame {3'b001, ~d, 3'b100}
//   frame_valid  frame1/frame2 hold a valid pair
//   frame_ready  downstream consumes the frame this cycle
//   fifo_count   nibbles currently buffered
//   frames_sent  accepted frames, modulo 256
module data_encryption_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [9:0]             frame1,
  output logic [9:0]             frame2,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             frames_sent
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GAP < 2) ? 1 : $clog2(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [9:0]    frame1_q, frame1_d;
  logic [9:0]    frame2_q, frame2_d;
  logic          valid_q, valid_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    sent_q, sent_d;
  logic          push_c, pop_c;
  logic [3:0]    head_c;

  function automatic logic [9:0] build_frame(input logic [3:0] d);
    return {3'b001, d, 3'b100};
  endfunction

  // No bypass: readiness depends only on the registered count.
  assign din_ready = !rst && (count_q < CW'(DEPTH));
  assign push_c    = din_valid && din_ready;
  assign head_c    = mem_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_SEND;
      end
      S_SEND: begin
        if (frame_ready) begin
          // With GAP == 1 the IDLE pass is itself the single idle cycle.
          if (GAP > 1)             state_d = S_GAP;
          else if (GAP == 1)       state_d = S_IDLE;
          else if (count_q == '0)  state_d = S_IDLE;
        end
      end
      S_GAP: begin
        // Leave while the last gap cycle is still counting; IDLE supplies it.
        if (gap_q <= GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    pop_c    = 1'b0;
    frame1_d = frame1_q;
    frame2_d = frame2_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    sent_d   = sent_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c    = 1'b1;
          frame1_d = build_frame(head_c);
          frame2_d = build_frame(~head_c);
          valid_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (frame_ready) begin
          sent_d   = sent_q + 8'd1;
          frame1_d = '0;
          frame2_d = '0;
          valid_d  = 1'b0;
          if (GAP > 1) begin
            gap_d = GW'(GAP - 1);
          end else if ((GAP == 0) && (count_q != '0)) begin
            // Back-to-back: load the next head on the accepting edge.
            pop_c    = 1'b1;
            frame1_d = build_frame(head_c);
            frame2_d = build_frame(~head_c);
            valid_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        gap_d = (gap_q == '0) ? '0 : gap_q - GW'(1);
      end
      default: ;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      frame1_q <= '0;
      frame2_q <= '0;
      valid_q  <= 1'b0;
      gap_q    <= '0;
      sent_q   <= '0;
    end else begin
      frame1_q <= frame1_d;
      frame2_q <= frame2_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= din;
  end

  assign frame1      = frame1_q;
  assign frame2      = frame2_q;
  assign frame_valid = valid_q;
  assign fifo_count  = count_q;
  assign frames_sent = sent_q;

endmodule

// File: tb/tb_data_encryption_tx.sv
// Bench for data_encryption_tx: a GAP=2 instance checked by a scoreboard and a
// receiver decode model, plus a GAP=0 instance for back-to-back frames.
module tb_data_encryption_tx;

  logic       clk, rst;
  logic [3:0] din;
  logic       din_valid, din_ready;
  logic [9:0] frame1, frame2;
  logic       frame_valid, frame_ready;
  logic [2:0] fifo_count;
  logic [7:0] frames_sent;

  logic [3:0] din0;
  logic       din_valid0, din_ready0;
  logic [9:0] frame1_0, frame2_0;
  logic       frame_valid0, frame_ready0;
  logic [2:0] fifo_count0;
  logic [7:0] frames_sent0;

  data_encryption_tx #(.DEPTH(4), .GAP(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .frame1(frame1), .frame2(frame2), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .fifo_count(fifo_count), .frames_sent(frames_sent)
  );

  data_encryption_tx #(.DEPTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(din_valid0), .din_ready(din_ready0),
    .frame1(frame1_0), .frame2(frame2_0), .frame_valid(frame_valid0),
    .frame_ready(frame_ready0), .fifo_count(fifo_count0), .frames_sent(frames_sent0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [9:0] f1;
    logic [9:0] f2;
    logic [4:0] rx;
  } vec_t;

  vec_t       tbl [16];
  logic [3:0] sbq [$];
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: valid frames decode to {d,1}, anything else to 0.
  function automatic logic [4:0] rx_decode(input logic [9:0] a, input logic [9:0] b);
    if (a[9:7] == 3'b001 && a[2:0] == 3'b100 && b[9:7] == 3'b001 &&
        b[2:0] == 3'b100 && b[6:3] == ~a[6:3])
      return {a[6:3], 1'b1};
    return 5'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (frame_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected_frame: got %0h/%0h, expected no frame", frame1, frame2);
        end else begin
          check("sb_frame1", 32'(frame1), 32'(tbl[sbq[0]].f1));
          check("sb_frame2", 32'(frame2), 32'(tbl[sbq[0]].f2));
          check("sb_rx", 32'(rx_decode(frame1, frame2)), 32'(tbl[sbq[0]].rx));
          if (frame_ready) void'(sbq.pop_front());
        end
      end else begin
        check("idle_frames", 32'({frame1, frame2}), 32'(0));
        check("idle_rx", 32'(rx_decode(frame1, frame2)), 32'(0));
      end
      if (din_valid && din_ready) sbq.push_back(din);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input string name, input int max);
    int c = 0;
    while ((sbq.size() != 0 || frame_valid || fifo_count != 3'd0) && c < max) begin
      tick();
      c++;
    end
    check(name, 32'(c < max), 32'(1));
  endtask

  task automatic push_wait(input logic [3:0] d);
    logic acc = 1'b0;
    din = d;
    din_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = din_ready;
      tick();
      if (acc) break;
    end
    din_valid = 1'b0;
    check("push_accept", 32'(acc), 32'(1));
  endtask

  initial begin
    tbl[0]  = '{4'h0, 10'h084, 10'h0FC, 5'h01};
    tbl[1]  = '{4'h1, 10'h08C, 10'h0F4, 5'h03};
    tbl[2]  = '{4'h2, 10'h094, 10'h0EC, 5'h05};
    tbl[3]  = '{4'h3, 10'h09C, 10'h0E4, 5'h07};
    tbl[4]  = '{4'h4, 10'h0A4, 10'h0DC, 5'h09};
    tbl[5]  = '{4'h5, 10'h0AC, 10'h0D4, 5'h0B};
    tbl[6]  = '{4'h6, 10'h0B4, 10'h0CC, 5'h0D};
    tbl[7]  = '{4'h7, 10'h0BC, 10'h0C4, 5'h0F};
    tbl[8]  = '{4'h8, 10'h0C4, 10'h0BC, 5'h11};
    tbl[9]  = '{4'h9, 10'h0CC, 10'h0B4, 5'h13};
    tbl[10] = '{4'hA, 10'h0D4, 10'h0AC, 5'h15};
    tbl[11] = '{4'hB, 10'h0DC, 10'h0A4, 5'h17};
    tbl[12] = '{4'hC, 10'h0E4, 10'h09C, 5'h19};
    tbl[13] = '{4'hD, 10'h0EC, 10'h094, 5'h1B};
    tbl[14] = '{4'hE, 10'h0F4, 10'h08C, 5'h1D};
    tbl[15] = '{4'hF, 10'h0FC, 10'h084, 5'h1F};

    rst = 1'b1;
    din = 4'h0; din_valid = 1'b0; frame_ready = 1'b0;
    din0 = 4'h0; din_valid0 = 1'b0; frame_ready0 = 1'b0;
    tick();
    tick();
    // Reset state, including din_ready low during the reset cycle.
    check("rst_din_ready", 32'(din_ready), 32'(0));
    check("rst_valid", 32'(frame_valid), 32'(0));
    check("rst_frames", 32'({frame1, frame2}), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_sent", 32'(frames_sent), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_din_ready", 32'(din_ready), 32'(1));

    // Every nibble through the table: latency, encoding, gap, frames_sent.
    frame_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = tbl[i].d;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check("vec_latency_low", 32'(frame_valid), 32'(0));
      tick();
      check("vec_valid", 32'(frame_valid), 32'(1));
      check("vec_frame1", 32'(frame1), 32'(tbl[i].f1));
      check("vec_frame2", 32'(frame2), 32'(tbl[i].f2));
      check("vec_rx", 32'(rx_decode(frame1, frame2)), 32'(tbl[i].rx));
      tick();
      check("vec_gap1", 32'({frame_valid, frame1, frame2}), 32'(0));
      check("vec_sent", 32'(frames_sent), 32'(i + 1));
      tick();
      check("vec_gap2", 32'({frame_valid, frame1, frame2}), 32'(0));
    end

    // 0 then F: exactly two idle cycles between the frames.
    do_reset();
    frame_ready = 1'b1;
    din = 4'h0; din_valid = 1'b1;
    tick();
    din = 4'hF;
    tick();
    din_valid = 1'b0;
    check("gap_first", 32'({frame_valid, frame1, frame2}), 32'({1'b1, 10'h084, 10'h0FC}));
    tick();
    check("gap_idle1", 32'({frame_valid, frame1, frame2}), 32'(0));
    tick();
    check("gap_idle2", 32'({frame_valid, frame1, frame2}), 32'(0));
    tick();
    check("gap_second", 32'({frame_valid, frame1, frame2}), 32'({1'b1, 10'h0FC, 10'h084}));
    wait_drain("gap_drain", 20);

    // Backpressure: hold frame, fill FIFO, reject excess nibbles.
    do_reset();
    frame_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      din = 4'(j + 1);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    check("bp_count_full", 32'(fifo_count), 32'(4));
    check("bp_din_ready", 32'(din_ready), 32'(0));
    check("bp_held", 32'({frame_valid, frame1}), 32'({1'b1, 10'h08C}));
    tick();
    tick();
    check("bp_still_held", 32'({frame_valid, frame1, frame2}), 32'({1'b1, 10'h08C, 10'h0F4}));
    frame_ready = 1'b1;
    wait_drain("bp_drain", 60);
    check("bp_sent", 32'(frames_sent), 32'(5));

    // GAP=0 instance: back-to-back frames 1, 2, 3.
    do_reset();
    din_valid0 = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      din0 = 4'(j);
      tick();
    end
    din_valid0 = 1'b0;
    check("b2b_count", 32'(fifo_count0), 32'(2));
    frame_ready0 = 1'b1;
    check("b2b_f1", 32'({frame_valid0, frame1_0, frame2_0}), 32'({1'b1, 10'h08C, 10'h0F4}));
    tick();
    check("b2b_f2", 32'({frame_valid0, frame1_0, frame2_0}), 32'({1'b1, 10'h094, 10'h0EC}));
    tick();
    check("b2b_f3", 32'({frame_valid0, frame1_0, frame2_0}), 32'({1'b1, 10'h09C, 10'h0E4}));
    tick();
    check("b2b_idle", 32'({frame_valid0, frame1_0, frame2_0}), 32'(0));
    check("b2b_sent", 32'(frames_sent0), 32'(3));
    tick();
    check("b2b_stays_idle", 32'(frame_valid0), 32'(0));
    frame_ready0 = 1'b0;

    // Reset while in SEND with two nibbles buffered.
    do_reset();
    frame_ready = 1'b0;
    din_valid = 1'b1;
    for (int j = 7; j <= 9; j++) begin
      din = 4'(j);
      tick();
    end
    din_valid = 1'b0;
    check("mid_count", 32'(fifo_count), 32'(2));
    check("mid_valid", 32'(frame_valid), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_din_ready", 32'(din_ready), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    check("mid_after_valid", 32'(frame_valid), 32'(0));
    check("mid_after_frames", 32'({frame1, frame2}), 32'(0));
    check("mid_after_count", 32'(fifo_count), 32'(0));
    check("mid_after_sent", 32'(frames_sent), 32'(0));
    frame_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("mid_no_emit", 32'(frame_valid), 32'(0));
    end

    // 260 frames: frames_sent wraps through 0 to 4.
    do_reset();
    frame_ready = 1'b1;
    for (int n = 0; n < 260; n++) push_wait(4'(n));
    wait_drain("wrap_drain", 100);
    check("wrap_sent", 32'(frames_sent), 32'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
